// File: rtl/cic_pdm_pkg.sv
// rtl/cic_pdm_pkg.sv - shared constants and helpers for the CIC PDM decimator
package cic_pdm_pkg;

  localparam int ORDER_MIN      = 1;
  localparam int ORDER_MAX      = 5;
  localparam int DECIM_LOG2_MIN = 2;
  localparam int DECIM_LOG2_MAX = 8;
  localparam int CHANNELS_MIN   = 1;
  localparam int CHANNELS_MAX   = 4;
  localparam int OUT_WIDTH_MIN  = 8;
  localparam int OUT_WIDTH_MAX  = 24;

  // Bits needed to hold +/-R^N growth of the integrator chain.
  function automatic int acc_width(input int order, input int decim_log2);
    return order * decim_log2 + 1;
  endfunction

  // Align the comb result to out_w bits, then clamp to the signed output range.
  function automatic logic signed [31:0] scale_sat(input logic signed [63:0] acc,
                                                   input int acc_w, input int out_w);
    logic signed [63:0] shifted;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (acc_w >= out_w) shifted = acc >>> (acc_w - out_w);
    else                shifted = acc <<< (out_w - acc_w);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (shifted > hi)      shifted = hi;
    else if (shifted < lo) shifted = lo;
    return shifted[31:0];
  endfunction

endpackage

// File: rtl/cic_pdm_decimator_channel.sv
// rtl/cic_pdm_decimator_channel.sv - integrator chain, comb pipeline and scaling for one channel
module cic_pdm_channel
  import cic_pdm_pkg::*;
#(
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 step,
  input  logic                 bit_in,
  input  logic                 capture,
  input  logic [ORDER-1:0]     comb_en,
  output logic [OUT_WIDTH-1:0] sample
);

  localparam int ACC_WIDTH = acc_width(ORDER, DECIM_LOG2);
  // One guard bit above ACC_WIDTH so that +R^N and -R^N stay distinct after the combs.
  localparam int DW = ACC_WIDTH + 1;

  logic signed [DW-1:0] integ   [ORDER];
  logic signed [DW-1:0] comb    [ORDER];
  logic signed [DW-1:0] dly     [ORDER];
  logic signed [DW-1:0] comb_in [ORDER];
  logic signed [DW-1:0] cap;
  logic signed [DW-1:0] mapped;
  logic signed [31:0]   scaled;
  logic                 unused_hi;

  assign mapped = bit_in ? {{(DW-1){1'b0}}, 1'b1} : {DW{1'b1}};

  // Integrators: stage 0 accumulates +/-1, later stages add the previous stage's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ORDER; i++) integ[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < ORDER; i++) integ[i] <= '0;
    end else if (step) begin
      integ[0] <= integ[0] + mapped;
      for (int i = 1; i < ORDER; i++) integ[i] <= integ[i] + integ[i-1];
    end
  end

  // Decimation point: hold the last integrator value when the capture token arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cap <= '0;
    else if (clear)   cap <= '0;
    else if (capture) cap <= integ[ORDER-1];
  end

  // Each comb stage takes the capture register or the previous comb output.
  always_comb begin
    comb_in[0] = cap;
    for (int k = 1; k < ORDER; k++) comb_in[k] = comb[k-1];
  end

  // Comb stages advance only as their token passes, so delays hold decimated history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        comb[k] <= '0;
        dly[k]  <= '0;
      end
    end else if (clear) begin
      for (int k = 0; k < ORDER; k++) begin
        comb[k] <= '0;
        dly[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < ORDER; k++) begin
        if (comb_en[k]) begin
          comb[k] <= comb_in[k] - dly[k];
          dly[k]  <= comb_in[k];
        end
      end
    end
  end

  assign scaled    = scale_sat({{(64-DW){comb[ORDER-1][DW-1]}}, comb[ORDER-1]}, ACC_WIDTH, OUT_WIDTH);
  assign sample    = scaled[OUT_WIDTH-1:0];
  assign unused_hi = ^scaled[31:OUT_WIDTH];

endmodule

// File: rtl/cic_pdm_decimator.sv
// rtl/cic_pdm_decimator.sv - multi-channel PDM to PCM CIC decimator top level
module cic_pdm_decimator
  import cic_pdm_pkg::*;
#(
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 6,
  parameter int CHANNELS   = 2,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          pdm_en,
  input  logic [CHANNELS-1:0]           pdm_in,
  output logic [CHANNELS*OUT_WIDTH-1:0] pcm_data,
  output logic                          pcm_valid,
  input  logic                          pcm_ready,
  output logic                          pcm_overrun
);

  if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
    $error("cic_pdm_decimator: ORDER out of range");
  end
  if (DECIM_LOG2 < DECIM_LOG2_MIN || DECIM_LOG2 > DECIM_LOG2_MAX) begin : g_bad_decim
    $error("cic_pdm_decimator: DECIM_LOG2 out of range");
  end
  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("cic_pdm_decimator: CHANNELS out of range");
  end
  if (OUT_WIDTH < OUT_WIDTH_MIN || OUT_WIDTH > OUT_WIDTH_MAX) begin : g_bad_width
    $error("cic_pdm_decimator: OUT_WIDTH out of range");
  end

  logic [DECIM_LOG2-1:0]         sample_cnt;
  logic [2:0]                    warm_cnt;
  // token[0]: capture, token[1..ORDER]: comb stages, token[ORDER+1]: result ready
  logic [ORDER+1:0]              token;
  logic                          clear;
  logic                          step;
  logic                          last_strobe;
  logic                          result;
  logic                          load;
  logic [CHANNELS*OUT_WIDTH-1:0] samples;

  assign clear       = !enable;
  assign step        = enable && pdm_en;
  assign last_strobe = step && (sample_cnt == '1);
  assign result      = token[ORDER+1];
  assign load        = result && (warm_cnt == 3'd0);

  // Strobe counter shared by all channels; wraps every R strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sample_cnt <= '0;
    else if (clear) sample_cnt <= '0;
    else if (step)  sample_cnt <= sample_cnt + DECIM_LOG2'(1);
  end

  // Token walks capture -> combs -> output; flushing kills anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     token <= '0;
    else if (clear) token <= '0;
    else            token <= {token[ORDER:0], last_strobe};
  end

  // Discard the first ORDER results while the comb delays still hold start-up history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            warm_cnt <= 3'(ORDER);
    else if (clear)                        warm_cnt <= 3'(ORDER);
    else if (result && warm_cnt != 3'd0)   warm_cnt <= warm_cnt - 3'd1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    cic_pdm_channel #(
      .ORDER      (ORDER),
      .DECIM_LOG2 (DECIM_LOG2),
      .OUT_WIDTH  (OUT_WIDTH)
    ) u_channel (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .step    (step),
      .bit_in  (pdm_in[c]),
      .capture (token[0]),
      .comb_en (token[ORDER:1]),
      .sample  (samples[c*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // Output register: new results always load; an unconsumed set being replaced flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_data    <= '0;
      pcm_valid   <= 1'b0;
      pcm_overrun <= 1'b0;
    end else if (clear) begin
      pcm_data    <= '0;
      pcm_valid   <= 1'b0;
      pcm_overrun <= 1'b0;
    end else begin
      pcm_overrun <= load && pcm_valid && !pcm_ready;
      if (load) begin
        pcm_data  <= samples;
        pcm_valid <= 1'b1;
      end else if (pcm_ready) begin
        pcm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_pdm_decimator.sv
// tb/tb_cic_pdm_decimator.sv - self-checking bench for cic_pdm_decimator
module tb_cic_pdm_decimator;

  localparam int N    = 3;
  localparam int L    = 6;
  localparam int R    = 1 << L;
  localparam int CH   = 2;
  localparam int OW   = 16;
  localparam int ACCW = N * L + 1;
  localparam int HLEN = N * (R - 1) + 1;
  localparam int MAXS = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               enable;
  logic               pdm_en;
  logic [CH-1:0]      pdm_in;
  logic [CH*OW-1:0]   pcm_data;
  logic               pcm_valid;
  logic               pcm_ready;
  logic               pcm_overrun;

  logic               s_enable;
  logic               s_pdm_en;
  logic [0:0]         s_pdm_in;
  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_ready;
  logic               s_overrun;

  cic_pdm_decimator dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pdm_en(pdm_en), .pdm_in(pdm_in),
    .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .pcm_overrun(pcm_overrun)
  );

  cic_pdm_decimator #(.ORDER(1), .DECIM_LOG2(2), .CHANNELS(1), .OUT_WIDTH(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(s_enable), .pdm_en(s_pdm_en), .pdm_in(s_pdm_in),
    .pcm_data(s_data), .pcm_valid(s_valid), .pcm_ready(s_ready), .pcm_overrun(s_overrun)
  );

  int     total = 0;
  int     bad   = 0;
  longint h [HLEN];
  int     hist [CH][MAXS];
  int     nstrobe, next_m, kedge, nvalid, novr, ovr_edge, first_valid;
  logic   prev_valid;
  longint last_d [CH];

  typedef struct { int p0; int p1; longint e0; longint e1; } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // CIC response as a direct FIR over the recorded +/-1 history, zero before the segment start.
  function automatic longint model_raw(input int c, input int m);
    longint acc;
    int     t;
    acc = 0;
    t = m * R + R - 1 - (N - 1);
    for (int j = 0; j < HLEN; j++)
      if (t - j >= 0) acc += h[j] * longint'(hist[c][t-j]);
    return acc;
  endfunction

  function automatic longint scale_ref(input longint v);
    longint s, hi, lo;
    if (ACCW >= OW) s = v >>> (ACCW - OW);
    else            s = v * (longint'(1) << (OW - ACCW));
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  function automatic longint sample_of(input int c);
    logic [OW-1:0] w;
    w = pcm_data[c*OW +: OW];
    return longint'($signed(w));
  endfunction

  function automatic logic pat(input int p, input int k);
    logic [31:0] kk;
    kk = k;
    if (p == 0) return 1'b0;
    if (p == 1) return 1'b1;
    return kk[0];
  endfunction

  task automatic begin_segment();
    enable = 1'b1;
    nstrobe = 0; next_m = N; kedge = 0; nvalid = 0; novr = 0; ovr_edge = -1; first_valid = -1;
    prev_valid = pcm_valid;
  endtask

  task automatic cyc(input logic pen, input logic [CH-1:0] bits, input logic rdy);
    pdm_en = pen; pdm_in = bits; pcm_ready = rdy;
    if (enable && rst_n && pen && nstrobe < MAXS) begin
      for (int c = 0; c < CH; c++) hist[c][nstrobe] = bits[c] ? 1 : -1;
      nstrobe++;
    end
    if (enable && rst_n && pcm_valid && rdy) begin
      for (int c = 0; c < CH; c++)
        check($sformatf("xfer m=%0d ch%0d", next_m, c), sample_of(c), scale_ref(model_raw(c, next_m)));
      next_m++;
    end
    @(posedge clk);
    @(negedge clk);
    kedge++;
    if (pcm_valid && !prev_valid) begin
      nvalid++;
      if (first_valid < 0) first_valid = kedge;
      for (int c = 0; c < CH; c++) last_d[c] = sample_of(c);
    end
    if (pcm_overrun) begin
      novr++;
      ovr_edge = kedge;
    end
    prev_valid = pcm_valid;
  endtask

  task automatic flush();
    enable = 1'b0;
    cyc(1'b0, '0, 1'b1);
    begin_segment();
  endtask

  initial begin
    longint tmp [HLEN];
    int     len;
    int     sc, e8, fv, sovr;
    int     results;
    longint sval;
    logic   sprev;

    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    len = 1;
    repeat (N) begin
      for (int i = 0; i < HLEN; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      len += R - 1;
      for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
    end

    vt[0] = '{p0: 1, p1: 1, e0:  32767, e1:  32767};
    vt[1] = '{p0: 0, p1: 0, e0: -32768, e1: -32768};
    vt[2] = '{p0: 2, p1: 1, e0:      0, e1:  32767};
    vt[3] = '{p0: 1, p1: 0, e0:  32767, e1: -32768};
    vt[4] = '{p0: 2, p1: 2, e0:      0, e1:      0};

    rst_n = 1'b0; enable = 1'b0; pdm_en = 1'b0; pdm_in = '0; pcm_ready = 1'b1;
    s_enable = 1'b0; s_pdm_en = 1'b0; s_pdm_in = '0; s_ready = 1'b1;
    prev_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset pcm_valid", longint'(pcm_valid), 0);
    check("reset pcm_data", longint'(pcm_data), 0);
    check("reset pcm_overrun", longint'(pcm_overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: steady-state patterns, warm-up position and output count.
    for (int v = 0; v < 5; v++) begin
      flush();
      for (int k = 0; k < 6 * R + 8; k++)
        cyc(1'b1, {pat(vt[v].p1, k), pat(vt[v].p0, k)}, 1'b1);
      check($sformatf("vec%0d first valid edge", v), first_valid, 261);
      check($sformatf("vec%0d valid count", v), nvalid, 3);
      check($sformatf("vec%0d ch0", v), last_d[0], vt[v].e0);
      check($sformatf("vec%0d ch1", v), last_d[1], vt[v].e1);
      check($sformatf("vec%0d overrun", v), novr, 0);
    end

    // Random bits, random strobes, random ready against the FIR model.
    flush();
    for (int k = 0; k < 1500; k++)
      cyc(logic'($urandom_range(0, 3) != 0), CH'($urandom), logic'($urandom_range(0, 1)));
    for (int k = 0; k < 20; k++) cyc(1'b0, '0, 1'b1);
    results = nstrobe / R;
    check("random result count", next_m, results);
    check("random overrun", novr, 0);

    // Ready held low across two results: overwrite with pulse.
    flush();
    for (int k = 1; k <= 327; k++) cyc(1'b1, CH'($urandom), 1'b0);
    check("ovr pulses", novr, 1);
    check("ovr edge", ovr_edge, 325);
    check("ovr valid", longint'(pcm_valid), 1);
    for (int c = 0; c < CH; c++)
      check($sformatf("ovr data ch%0d", c), sample_of(c), scale_ref(model_raw(c, 4)));

    // Ready high on the load cycle: old set transfers, new loads, no pulse.
    flush();
    for (int k = 1; k <= 327; k++) cyc(1'b1, CH'($urandom), logic'(k == 325));
    check("ready-on-load pulses", novr, 0);
    check("ready-on-load valid", longint'(pcm_valid), 1);
    check("ready-on-load transfers", next_m, 4);
    for (int c = 0; c < CH; c++)
      check($sformatf("ready-on-load data ch%0d", c), sample_of(c), scale_ref(model_raw(c, 4)));

    // Enable dropped two cycles after a capture kills the in-flight token.
    flush();
    for (int k = 1; k <= 322; k++) cyc(1'b1, CH'($urandom), 1'b1);
    check("drop valid before", nvalid, 1);
    enable = 1'b0;
    cyc(1'b1, CH'($urandom), 1'b1);
    check("drop valid low", longint'(pcm_valid), 0);
    begin_segment();
    for (int k = 1; k <= 262; k++) cyc(1'b1, CH'($urandom), 1'b1);
    check("drop rewarm first valid", first_valid, 261);
    check("drop rewarm count", nvalid, 1);

    // Asynchronous reset mid-stream clears outputs at once and restarts warm-up.
    flush();
    for (int k = 1; k <= 330; k++) cyc(1'b1, CH'($urandom), 1'b0);
    check("pre-reset valid", longint'(pcm_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset valid", longint'(pcm_valid), 0);
    check("async reset data", longint'(pcm_data), 0);
    check("async reset overrun", longint'(pcm_overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin_segment();
    for (int k = 1; k <= 262; k++) cyc(1'b1, CH'($urandom), 1'b1);
    check("reset rewarm first valid", first_valid, 261);
    check("reset rewarm count", nvalid, 1);

    // ORDER=1, R=4, 8-bit output: latency after the second window's 4th strobe, saturation.
    for (int p = 0; p < 2; p++) begin
      s_enable = 1'b0; s_pdm_en = 1'b0; s_ready = 1'b1; s_pdm_in = 1'(p == 0);
      @(posedge clk);
      @(negedge clk);
      s_enable = 1'b1; sc = 0; e8 = -1; fv = -1; sovr = 0; sprev = 1'b0; sval = 0;
      for (int k = 1; k <= 40; k++) begin
        s_pdm_en = ((k - 1) % 4 == 0);
        if (s_pdm_en) sc++;
        @(posedge clk);
        @(negedge clk);
        if (s_pdm_en && sc == 8) e8 = k;
        if (s_valid && !sprev && fv < 0) begin
          fv = k;
          sval = longint'($signed(s_data));
        end
        if (s_overrun) sovr++;
        sprev = s_valid;
      end
      check($sformatf("small p%0d strobe8 edge", p), e8, 29);
      check($sformatf("small p%0d latency", p), fv - e8, 3);
      check($sformatf("small p%0d value", p), sval, (p == 0) ? 127 : -128);
      check($sformatf("small p%0d overrun", p), sovr, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
